// File: rtl/seg_scan_capture.sv
// seg_scan_capture
//   Reads a time-multiplexed, active-low 7-segment display bus and converts
//   the glyphs back into packed BCD digits. Each digit is accepted only after
//   its (an, seg) pattern has held for STABLE_CYCLES consecutive samples. A
//   frame is reported once every digit position has been captured once.
//
//   Optional feature macro: SEG_SYNC_EN
//     defined   - an/seg pass through a two-stage synchronizer (+2 cycles)
//     undefined - an/seg are sampled directly (bus synchronous to clk)
//
// Ports:
//   clk          system clock
//   rst_n        synchronous reset, active-low
//   an           digit enables, active-low; an[0] is the least-significant digit
//   seg          segments, active-low; seg[0]=a .. seg[6]=g
//   start        single-cycle pulse arming a frame capture
//   busy         high from the cycle after start until frame_valid or timeout
//   bcd_out      captured digits; digit i at [4i+3:4i]
//   blank_mask   bit i set when digit i was captured as blank
//   frame_valid  one-cycle pulse; bcd_out/blank_mask valid from this cycle on
//   timeout      one-cycle pulse when a frame is aborted
//   err_invalid  sticky flag for an accepted non-digit, non-blank glyph

module seg_scan_capture #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_DIGITS-1:0]     an,
    input  logic [6:0]                seg,
    input  logic                      start,
    output logic                      busy,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     blank_mask,
    output logic                      frame_valid,
    output logic                      timeout,
    output logic                      err_invalid
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_COMMIT,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] an_s;
    logic [6:0]            seg_s;

`ifdef SEG_SYNC_EN
    logic [NUM_DIGITS-1:0] an_m;
    logic [6:0]            seg_m;

    // Reset values correspond to an idle bus: no anode on, all segments off.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_m  <= '1;
            an_s  <= '1;
            seg_m <= 7'h7F;
            seg_s <= 7'h7F;
        end else begin
            an_m  <= an;
            an_s  <= an_m;
            seg_m <= seg;
            seg_s <= seg_m;
        end
    end
`else
    assign an_s  = an;
    assign seg_s = seg;
`endif

    // ------------------------------------------------------------------
    // Sample legality: exactly one anode low
    // ------------------------------------------------------------------
    int unsigned   low_cnt;
    logic [IW-1:0] cur_idx;
    logic          one_low;

    always_comb begin
        low_cnt = 0;
        cur_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                low_cnt = low_cnt + 1;
                cur_idx = IW'(i);
            end
        end
        one_low = (low_cnt == 1);
    end

    // ------------------------------------------------------------------
    // Stability tracking. prev_* hold the sample that stab_cnt describes,
    // so the FSM commits prev_seg for digit stab_idx.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] prev_an;
    logic [6:0]            prev_seg;
    logic [CW-1:0]         stab_cnt;
    logic [IW-1:0]         stab_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_an  <= '1;
            prev_seg <= 7'h7F;
            stab_cnt <= '0;
            stab_idx <= '0;
        end else begin
            prev_an  <= an_s;
            prev_seg <= seg_s;
            stab_idx <= cur_idx;
            if (!one_low) begin
                stab_cnt <= '0;
            end else if (an_s == prev_an && seg_s == prev_seg) begin
                if (stab_cnt != CW'(STABLE_CYCLES))
                    stab_cnt <= stab_cnt + CW'(1);
            end else begin
                stab_cnt <= CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Glyph decode: returns {blank, invalid, digit}
    // ------------------------------------------------------------------
    function automatic logic [5:0] decode_glyph(input logic [6:0] g);
        case (g)
            7'h40:   return {2'b00, 4'd0};
            7'h79:   return {2'b00, 4'd1};
            7'h24:   return {2'b00, 4'd2};
            7'h30:   return {2'b00, 4'd3};
            7'h19:   return {2'b00, 4'd4};
            7'h12:   return {2'b00, 4'd5};
            7'h02:   return {2'b00, 4'd6};
            7'h78:   return {2'b00, 4'd7};
            7'h00:   return {2'b00, 4'd8};
            7'h10:   return {2'b00, 4'd9};
            7'h7F:   return {2'b10, 4'd0};
            default: return {2'b01, 4'hF};
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                  state;
    logic [NUM_DIGITS-1:0]   captured;
    logic [TW-1:0]           tmo_cnt;
    logic [IW-1:0]           commit_idx;
    logic [6:0]              commit_glyph;
    logic [4*NUM_DIGITS-1:0] stage_bcd;
    logic [NUM_DIGITS-1:0]   stage_blank;

    logic [5:0]              commit_dec;
    logic [NUM_DIGITS-1:0]   captured_nx;
    logic [4*NUM_DIGITS-1:0] stage_bcd_nx;
    logic [NUM_DIGITS-1:0]   stage_blank_nx;
    logic                    tmo_expire;

    // Staging contents after the pending commit; lets the COMMIT cycle both
    // update staging and, on the final digit, publish the whole frame.
    always_comb begin
        commit_dec                           = decode_glyph(commit_glyph);
        captured_nx                          = captured;
        stage_bcd_nx                         = stage_bcd;
        stage_blank_nx                       = stage_blank;
        captured_nx[commit_idx]              = 1'b1;
        stage_bcd_nx[{commit_idx, 2'b00} +: 4] = commit_dec[3:0];
        stage_blank_nx[commit_idx]           = commit_dec[5];
    end

    assign tmo_expire = (tmo_cnt == TW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            frame_valid  <= 1'b0;
            timeout      <= 1'b0;
            err_invalid  <= 1'b0;
            bcd_out      <= '0;
            blank_mask   <= '0;
            captured     <= '0;
            tmo_cnt      <= '0;
            commit_idx   <= '0;
            commit_glyph <= 7'h7F;
            stage_bcd    <= '0;
            stage_blank  <= '0;
        end else begin
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        captured    <= '0;
                        err_invalid <= 1'b0;
                        tmo_cnt     <= TW'(TIMEOUT_CYCLES);
                        stage_bcd   <= '0;
                        stage_blank <= '0;
                        busy        <= 1'b1;
                        state       <= S_ARM;
                    end
                end
                S_ARM: begin
                    tmo_cnt <= tmo_cnt - TW'(1);
                    if (tmo_expire) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else if (stab_cnt == CW'(STABLE_CYCLES) && !captured[stab_idx]) begin
                        commit_idx   <= stab_idx;
                        commit_glyph <= prev_seg;
                        state        <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    tmo_cnt     <= tmo_cnt - TW'(1);
                    captured    <= captured_nx;
                    stage_bcd   <= stage_bcd_nx;
                    stage_blank <= stage_blank_nx;
                    if (commit_dec[4])
                        err_invalid <= 1'b1;
                    // Completion is checked before expiry so it wins a tie.
                    if (&captured_nx) begin
                        bcd_out     <= stage_bcd_nx;
                        blank_mask  <= stage_blank_nx;
                        frame_valid <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_DONE;
                    end else if (tmo_expire) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        state <= S_ARM;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture (default build, SEG_SYNC_EN undefined).
// The reference model derives capture times and frame contents directly from
// run lengths of identical legal bus samples.

module tb_seg_scan_capture;

    localparam int ND = 4;
    localparam int SC = 16;
    localparam int TO = 200;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  an    = 4'hF;
    logic [6:0]  seg   = 7'h7F;
    logic        busy;
    logic [15:0] bcd_out;
    logic [3:0]  blank_mask;
    logic        frame_valid;
    logic        timeout;
    logic        err_invalid;

    seg_scan_capture #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .an         (an),
        .seg        (seg),
        .start      (start),
        .busy       (busy),
        .bcd_out    (bcd_out),
        .blank_mask (blank_mask),
        .frame_valid(frame_valid),
        .timeout    (timeout),
        .err_invalid(err_invalid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [3:0]  q_an[$];
    logic [6:0]  q_seg[$];
    logic [15:0] exp_bcd   = 16'h0;
    logic [3:0]  exp_blank = 4'h0;
    logic        exp_err   = 1'b0;

    logic [6:0] glyphs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic add_raw(input logic [3:0] a, input logic [6:0] g, input int len);
        for (int i = 0; i < len; i++) begin
            q_an.push_back(a);
            q_seg.push_back(g);
        end
    endtask

    task automatic add_digit(input int k, input logic [6:0] g, input int len);
        logic [3:0] a;
        a    = 4'hF;
        a[k] = 1'b0;
        add_raw(a, g, len);
    endtask

    task automatic decode_ref(input logic [6:0] g, output logic [3:0] d,
                              output logic bl, output logic inv);
        d   = 4'hF;
        bl  = 1'b0;
        inv = 1'b1;
        if (g == 7'h7F) begin
            d   = 4'h0;
            bl  = 1'b1;
            inv = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            if (glyphs[i] == g) begin
                d   = 4'(i);
                inv = 1'b0;
            end
        end
    endtask

    // Sample j (1-based) is taken at the j-th clock edge after the start edge.
    // A digit whose run of identical legal samples reaches SC at sample j is
    // committed two edges later; anything not committed by edge TO is lost.
    task automatic model(output int done_e, output logic [15:0] bcd,
                         output logic [3:0] blank, output logic err);
        logic [10:0] prev, cur;
        int          run, k;
        logic [3:0]  cap, d;
        logic        bl, inv;
        prev   = {4'hF, 7'h7F};
        run    = 0;
        cap    = 4'h0;
        bcd    = 16'h0;
        blank  = 4'h0;
        err    = 1'b0;
        done_e = 0;
        for (int j = 1; j <= TO - 2 && done_e == 0; j++) begin
            if (j <= q_an.size()) cur = {q_an[j-1], q_seg[j-1]};
            else                  cur = {4'hF, 7'h7F};
            if ($countones(~cur[10:7]) != 1) run = 0;
            else if (cur == prev)             run++;
            else                              run = 1;
            prev = cur;
            if (run >= SC) begin
                k = 0;
                for (int i = 0; i < 4; i++) if (!cur[7+i]) k = i;
                if (!cap[k]) begin
                    cap[k] = 1'b1;
                    decode_ref(cur[6:0], d, bl, inv);
                    bcd[4*k +: 4] = d;
                    blank[k]      = bl;
                    err           = err | inv;
                    if (cap == 4'hF) done_e = j + 2;
                end
            end
        end
    endtask

    task automatic run_frame(input string name, input bit start_at_done, output int fv_e);
        int          done_e, fv_n, to_e, to_n, busy_bad, lim, end_e;
        logic [15:0] m_bcd;
        logic [3:0]  m_blank;
        logic        m_err;
        model(done_e, m_bcd, m_blank, m_err);
        chk({name, " err sticky before start"}, 32'(err_invalid), 32'(exp_err));
        @(negedge clk);
        an    = 4'hF;
        seg   = 7'h7F;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, " busy/err after start"}, {30'h0, busy, err_invalid}, 32'h2);
        if (q_an.size() > 0) begin
            an  = q_an[0];
            seg = q_seg[0];
        end
        fv_e = 0; fv_n = 0; to_e = 0; to_n = 0; busy_bad = 0;
        end_e = (done_e != 0) ? done_e : TO;
        lim   = end_e + 4;
        for (int n = 1; n <= lim; n++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin fv_n++; if (fv_e == 0) fv_e = n; end
            if (timeout)     begin to_n++; if (to_e == 0) to_e = n; end
            if (busy !== (n < end_e)) busy_bad++;
            start = start_at_done && fv_e != 0 && n == fv_e;
            if (n < q_an.size()) begin
                an  = q_an[n];
                seg = q_seg[n];
            end else begin
                an  = 4'hF;
                seg = 7'h7F;
            end
        end
        start = 1'b0;
        an    = 4'hF;
        seg   = 7'h7F;
        if (done_e != 0) begin
            chk({name, " frame_valid count/edge"}, {16'(fv_n), 16'(fv_e)}, {16'd1, 16'(done_e)});
            chk({name, " timeout count"}, 32'(to_n), 32'd0);
            exp_bcd   = m_bcd;
            exp_blank = m_blank;
        end else begin
            chk({name, " frame_valid count"}, 32'(fv_n), 32'd0);
            chk({name, " timeout count/edge"}, {16'(to_n), 16'(to_e)}, {16'd1, 16'(TO)});
        end
        exp_err = m_err;
        chk({name, " busy profile errors"}, 32'(busy_bad), 32'd0);
        chk({name, " bcd_out"}, 32'(bcd_out), 32'(exp_bcd));
        chk({name, " blank_mask"}, 32'(blank_mask), 32'(exp_blank));
        chk({name, " err_invalid"}, 32'(err_invalid), 32'(exp_err));
        q_an.delete();
        q_seg.delete();
    endtask

    task automatic build_random(input int passes, input int lo, input int hi);
        int         r;
        logic [6:0] g;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < 4; k++) begin
                r = $urandom_range(0, 11);
                if (r < 10)       g = glyphs[r];
                else if (r == 10) g = 7'h7F;
                else              g = 7'($urandom);
                if ($urandom_range(0, 7) == 0) add_raw(4'($urandom), 7'($urandom), 1);
                add_digit(k, g, $urandom_range(lo, hi));
            end
        end
    endtask

    initial begin
        int          fv;
        int          pulses;
        logic [15:0] prior_bcd;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {8'h0, busy, frame_valid, timeout, err_invalid, blank_mask, bcd_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic "1234", with a start pulse during the frame_valid cycle
        add_digit(0, glyphs[4], 20);
        add_digit(1, glyphs[3], 20);
        add_digit(2, glyphs[2], 20);
        add_digit(3, glyphs[1], 20);
        run_frame("basic", 1'b1, fv);
        chk("basic bcd constant", 32'(bcd_out), 32'h1234);
        chk("basic latency", 32'(fv), 32'(60 + SC + 2));
        chk("basic blank/err", {27'h0, blank_mask, err_invalid}, 32'h0);

        // Glitch rejection
        add_digit(0, 7'h24, 10);
        add_digit(0, 7'h30, 20);
        add_digit(1, glyphs[1], 10);
        add_raw(4'b1100, glyphs[1], 1);
        add_digit(1, glyphs[1], 10);
        add_digit(1, glyphs[5], 20);
        add_digit(2, glyphs[9], 20);
        add_digit(3, glyphs[0], 20);
        run_frame("glitch", 1'b0, fv);
        chk("glitch digit0", 32'(bcd_out[3:0]), 32'h3);
        chk("glitch digit1", 32'(bcd_out[7:4]), 32'h5);

        // Blank and invalid glyphs
        add_digit(0, glyphs[7], 20);
        add_digit(1, glyphs[8], 20);
        add_digit(2, 7'h55, 20);
        add_digit(3, 7'h7F, 20);
        run_frame("blank_invalid", 1'b0, fv);
        chk("blank mask constant", 32'(blank_mask), 32'h8);
        chk("invalid digit2", 32'(bcd_out[11:8]), 32'hF);
        chk("invalid err set", 32'(err_invalid), 32'h1);
        repeat (5) @(posedge clk);
        #1;
        chk("invalid err held", 32'(err_invalid), 32'h1);

        // Randomized frames, some with short holds that miss digits
        for (int r = 0; r < 6; r++) begin
            build_random(2, 12, 24);
            run_frame("random", 1'b0, fv);
        end

        // Timeout: digit 3 never shown
        add_digit(0, glyphs[6], 20);
        add_digit(1, glyphs[2], 20);
        add_digit(2, glyphs[9], 20);
        prior_bcd = exp_bcd;
        run_frame("timeout", 1'b0, fv);
        chk("timeout bcd held", 32'(bcd_out), 32'(prior_bcd));

        // Reset mid-frame after two digits are captured
        add_digit(0, glyphs[5], 20);
        add_digit(1, glyphs[6], 25);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        pulses = 0;
        for (int n = 0; n < 45; n++) begin
            an  = q_an[n];
            seg = q_seg[n];
            @(posedge clk);
            #1;
            if (frame_valid || timeout) pulses++;
        end
        chk("midreset busy before reset", 32'(busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 7'h7F;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            if (frame_valid || timeout) pulses++;
        end
        chk("midreset no pulses", 32'(pulses), 32'h0);
        chk("midreset outputs", {8'h0, busy, frame_valid, timeout, err_invalid, blank_mask, bcd_out}, 32'h0);
        q_an.delete();
        q_seg.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        exp_bcd   = 16'h0;
        exp_blank = 4'h0;
        exp_err   = 1'b0;

        // Fresh full frame after reset
        build_random(1, 18, 22);
        run_frame("post_reset", 1'b0, fv);
        add_digit(0, glyphs[8], 20);
        add_digit(1, glyphs[0], 20);
        add_digit(2, glyphs[7], 20);
        add_digit(3, glyphs[9], 20);
        run_frame("post_reset2", 1'b0, fv);
        chk("post_reset2 bcd constant", 32'(bcd_out), 32'h9708);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
